// File: rtl/mem_arbiter.sv
// mem_arbiter: alternating fetch/data arbiter for one shared single-port memory with flush drop and timeout abort
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            flush,
  output logic [DW-1:0]   if_rdata,
  output logic            if_valid,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_bmask,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_bmask,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            err
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  state_t state;
  logic drop, last_data, tout, done, grant_d;
  logic [7:0] wait_cnt;
  // a requester whose valid is pulsing this cycle is still holding req; masking it prevents a duplicate grant
  assign stall_if = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;
  assign mem_req = state != IDLE;
  assign tout = wait_cnt == 8'(TIMEOUT - 1);
  assign done = mem_req & (mem_ack | tout);
  assign grant_d = stall_mem & (~stall_if | ~last_data);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_bmask <= '0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      drop <= 1'b0;
      wait_cnt <= '0;
      last_data <= 1'b0;
      err <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if (state == IDLE) begin
        wait_cnt <= '0;
        drop <= 1'b0;
        if (grant_d) begin
          state <= DATA;
          mem_we <= dm_we;
          mem_addr <= dm_addr;
          mem_wdata <= dm_wdata;
          mem_bmask <= dm_bmask;
        end else if (stall_if) begin
          state <= FETCH;
          mem_we <= 1'b0;
          mem_addr <= if_addr;
          mem_wdata <= '0;
          mem_bmask <= '0;
        end
      end else if (done) begin
        state <= IDLE;
        wait_cnt <= '0;
        last_data <= state == DATA;
        err <= err | ~mem_ack;
        if (state == DATA) begin
          dm_valid <= 1'b1;
          dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
        end else if (!(drop || flush)) begin
          if_valid <= 1'b1;
          if_rdata <= mem_ack ? mem_rdata : '0;
        end
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
        if (state == FETCH && flush) drop <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized requesters and memory checked against a transaction-level model
module tb_mem_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, flush = 0, if_valid, dm_req = 0, dm_we = 0, dm_valid;
  logic [31:0] if_addr = 0, if_rdata, dm_addr = 0, dm_wdata = 0, dm_rdata;
  logic [3:0] dm_bmask = 0, mem_bmask;
  logic mem_req, mem_we, mem_ack = 0, stall_if, stall_mem, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_bmask(dm_bmask), .dm_rdata(dm_rdata),
    .dm_valid(dm_valid), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_bmask(mem_bmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ack_after(input int n, input logic [31:0] d);
    repeat (n) tick();
    mem_ack = 1;
    mem_rdata = d;
    tick();
    mem_ack = 0;
    mem_rdata = 0;
  endtask
  logic [31:0] marr [16];
  logic [31:0] if_a, dm_a, dm_wd, exp_rd;
  logic [3:0] dm_bm, idx;
  bit if_p, if_fin, dm_p, dm_fin, dm_w, act, own_d, done, gexp, g_d, last_d, eff_i, eff_d, mreq;
  int lat;
  initial begin
    repeat (3) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_valids", {if_valid, dm_valid}, 0);
    chk("rst_rdata", if_rdata | dm_rdata, 0);
    chk("rst_err", err, 0);
    rst = 0;
    tick();
    chk("idle_ack_ignored", mem_req, 0);
    if_req = 1; if_addr = 32'h100;
    tick();
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we", mem_we, 0);
    chk("f_stall_if", stall_if, 1);
    ack_after(3, 32'h1357_9BDF);
    chk("f_if_valid", if_valid, 1);
    chk("f_if_rdata", if_rdata, 32'h1357_9BDF);
    chk("f_stall_if_done", stall_if, 0);
    chk("f_err", err, 0);
    if_req = 0;
    tick();
    chk("f_pulse_one", if_valid, 0);
    chk("f_no_regrant", mem_req, 0);
    rst = 1; tick(); rst = 0;
    if_req = 1; if_addr = 32'h104;
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_bmask = 4'hF;
    tick();
    chk("c1_addr", mem_addr, 32'h200);
    chk("c1_we", mem_we, 1);
    chk("c1_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("c1_bmask", mem_bmask, 4'hF);
    ack_after(1, 32'hFFFF_0000);
    chk("c1_dm_valid", dm_valid, 1);
    chk("c1_store_rdata", dm_rdata, 0);
    chk("c1_if_valid", if_valid, 0);
    tick();
    chk("c2_addr", mem_addr, 32'h104);
    chk("c2_we", mem_we, 0);
    ack_after(0, 32'hA5A5_A5A5);
    chk("c2_if_valid", if_valid, 1);
    chk("c2_if_rdata", if_rdata, 32'hA5A5_A5A5);
    tick();
    chk("c3_req", mem_req, 1);
    chk("c3_addr", mem_addr, 32'h200);
    ack_after(0, 0);
    chk("c3_dm_valid", dm_valid, 1);
    if_req = 0; dm_req = 0;
    tick();
    chk("c_idle", mem_req, 0);
    if_req = 1; if_addr = 32'h108;
    tick();
    flush = 1;
    tick();
    flush = 0;
    ack_after(1, 32'h1111_1111);
    chk("fl_no_valid", if_valid, 0);
    chk("fl_stall_if", stall_if, 1);
    if_addr = 32'h300;
    tick();
    chk("fl_refetch_req", mem_req, 1);
    chk("fl_refetch_addr", mem_addr, 32'h300);
    ack_after(0, 32'h3030_3030);
    chk("fl_refetch_valid", if_valid, 1);
    chk("fl_refetch_rdata", if_rdata, 32'h3030_3030);
    chk("fl_stall_clear", stall_if, 0);
    if_req = 0; if_addr = 32'h10C;
    tick();
    if_req = 1;
    tick();
    flush = 1;
    ack_after(0, 32'h4444_4444);
    flush = 0;
    chk("fa_no_valid", if_valid, 0);
    if_req = 0;
    tick();
    chk("fa_no_valid_late", if_valid, 0);
    dm_req = 1; dm_we = 0; dm_addr = 32'h40; mem_rdata = 32'hBAD0_BAD0;
    tick();
    chk("to_req", mem_req, 1);
    repeat (3) tick();
    chk("to_busy4", mem_req, 1);
    tick();
    chk("to_idle", mem_req, 0);
    chk("to_dm_valid", dm_valid, 1);
    chk("to_rdata", dm_rdata, 0);
    chk("to_err", err, 1);
    dm_req = 0; mem_rdata = 0;
    tick();
    chk("to_pulse_one", dm_valid, 0);
    chk("to_err_sticky", err, 1);
    dm_req = 1; dm_addr = 32'h44;
    tick();
    chk("rm_busy", mem_req, 1);
    rst = 1; dm_req = 0;
    tick();
    chk("rm_req_low", mem_req, 0);
    chk("rm_err_clr", err, 0);
    rst = 0; mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("rm_no_valid", dm_valid, 0);
    chk("rm_late_ack", mem_req, 0);
    tick();
    chk("rm_no_valid2", dm_valid, 0);
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 16; i++) marr[i] = $urandom;
    if_p = 0; if_fin = 0; dm_p = 0; dm_fin = 0; act = 0; done = 0; gexp = 0; last_d = 0; lat = 0; own_d = 0;
    if_a = 0; dm_a = 0; dm_w = 0; dm_wd = 0; dm_bm = 0; exp_rd = 0;
    for (int c = 0; c < 800; c++) begin
      tick();
      mem_ack = 0; mem_rdata = 0;
      if (if_fin) begin if_p = 0; if_fin = 0; end
      if (dm_fin) begin dm_p = 0; dm_fin = 0; end
      chk("r_if_valid", if_valid, done && !own_d);
      chk("r_dm_valid", dm_valid, done && own_d);
      if (done) begin
        chk("r_rdata", own_d ? dm_rdata : if_rdata, exp_rd);
        last_d = own_d;
        if (own_d) dm_fin = 1; else if_fin = 1;
      end
      mreq = act || gexp;
      chk("r_mem_req", mem_req, mreq);
      if (gexp) begin act = 1; own_d = g_d; lat = $urandom_range(0, 2); end
      if (act) begin
        chk("r_mem_addr", mem_addr, own_d ? dm_a : if_a);
        chk("r_mem_we", mem_we, own_d && dm_w);
        if (own_d && dm_w) chk("r_wdata", {mem_bmask, mem_wdata[27:0]}, {dm_bm, dm_wd[27:0]});
      end
      done = 0;
      if (act) begin
        if (lat == 0) begin
          idx = own_d ? dm_a[5:2] : if_a[5:2];
          mem_ack = 1;
          if (own_d && dm_w) begin
            mem_rdata = $urandom;
            exp_rd = 0;
            for (int b = 0; b < 4; b++) if (dm_bm[b]) marr[idx][8*b +: 8] = dm_wd[8*b +: 8];
          end else begin
            mem_rdata = marr[idx];
            exp_rd = marr[idx];
          end
          act = 0;
          done = 1;
        end else lat--;
      end
      if (!if_p && $urandom_range(0, 1) == 1) begin
        if_p = 1;
        if_a = 32'($urandom_range(0, 15)) << 2;
      end
      if (!dm_p && $urandom_range(0, 2) == 0) begin
        dm_p = 1;
        dm_w = $urandom_range(0, 1) == 1;
        dm_a = 32'($urandom_range(0, 15)) << 2;
        dm_wd = $urandom;
        dm_bm = 4'($urandom_range(1, 15));
      end
      if_req = if_p; if_addr = if_a;
      dm_req = dm_p; dm_we = dm_w; dm_addr = dm_a; dm_wdata = dm_wd; dm_bmask = dm_bm;
      eff_i = if_p && !if_fin;
      eff_d = dm_p && !dm_fin;
      gexp = !mreq && (eff_i || eff_d);
      g_d = eff_d && (!eff_i || !last_d);
      #1;
      chk("r_stall_if", stall_if, eff_i);
      chk("r_stall_mem", stall_mem, eff_d);
    end
    chk("r_err", err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
